// File: rtl/alu_pkg.sv
// Shared ALU encodings plus the op and state encodings
// used by the multiply/divide sequencer.
package alu_pkg;

  localparam logic [2:0] ALUCONT_AND = 3'b000;
  localparam logic [2:0] ALUCONT_OR  = 3'b001;
  localparam logic [2:0] ALUCONT_ADD = 3'b010;
  localparam logic [2:0] ALUCONT_SUB = 3'b110;
  localparam logic [2:0] ALUCONT_SLT = 3'b111;

  typedef enum logic {
    OP_MULU = 1'b0,
    OP_DIVU = 1'b1
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_carry.sv
// Rebuilds carry-out (add) or no-borrow (sub) from the
// operand and result MSBs of an ALU that exports only its sum.
module alu_carry (
  input  logic a7,
  input  logic b7,
  input  logic s7,
  input  logic sub,
  output logic c
);

  logic bb;

  // Subtract is a + ~b + 1, so the effective b MSB is inverted
  always_comb begin
    bb = sub ? ~b7 : b7;
    c  = (a7 & bb) | ((a7 | bb) & ~s7);
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiply / restoring divide driven through the shared ALU.
// Build option MULDIV_EARLY_EXIT_EN: MULU stops once the multiplier is exhausted.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cont,
  input  logic [WIDTH-1:0] alu_result
);

  state_e           state;
  state_e           state_nx;
  op_e              op_q;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] l;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;

  logic             is_div;
  logic [WIDTH-1:0] rs;
  logic             r8;
  logic             c;
  logic             take;
  logic [WIDTH-1:0] h_nx;
  logic [WIDTH-1:0] l_nx;
  logic [2*WIDTH-1:0] res_nx;
  logic             early;
  logic             last;
  logic             accept;
  logic             finish;

  assign is_div = (op_q == OP_DIVU);
  assign rs     = {h[WIDTH-2:0], l[WIDTH-1]};
  assign r8     = h[WIDTH-1];
  assign busy   = (state == RUN);
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  alu_carry u_carry (
    .a7  (alu_a[WIDTH-1]),
    .b7  (alu_b[WIDTH-1]),
    .s7  (alu_result[WIDTH-1]),
    .sub (is_div),
    .c   (c)
  );

`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0]   mask;
  logic [CNT_W-1:0]   sh;
  logic [2*WIDTH-1:0] hl_sh;

  // Remaining multiplier bits sit in the low WIDTH-cnt bits of L
  always_comb begin
    mask  = {WIDTH{1'b1}} >> cnt;
    sh    = CNT_W'(WIDTH) - cnt;
    hl_sh = {h, l} >> sh;
    early = !is_div && ((l & mask) == '0);
  end
`else
  assign early = 1'b0;
`endif

  // Next-iteration values for the shared H/L registers
  always_comb begin
    take = 1'b0;
    h_nx = {c, alu_result[WIDTH-1:1]};
    l_nx = {alu_result[0], l[WIDTH-1:1]};
    if (is_div) begin
      take = r8 | c;
      h_nx = take ? alu_result : rs;
      l_nx = {l[WIDTH-2:0], take};
    end
`ifdef MULDIV_EARLY_EXIT_EN
    res_nx = early ? hl_sh : {h_nx, l_nx};
`else
    res_nx = {h_nx, l_nx};
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and ALU drive
  always_comb begin
    state_nx = state;
    alu_a    = '0;
    alu_b    = '0;
    alu_cont = ALUCONT_AND;
    accept   = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        finish = last | early;
        if (is_div) begin
          alu_cont = ALUCONT_SUB;
          alu_a    = rs;
          alu_b    = m;
        end else begin
          alu_cont = ALUCONT_ADD;
          alu_a    = h;
          alu_b    = l[0] ? m : '0;
        end
        if (finish) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_MULU;
      h        <= '0;
      l        <= '0;
      m        <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q     <= op_e'(op);
        h        <= '0;
        l        <= op ? op_a : op_b;
        m        <= op ? op_b : op_a;
        cnt      <= '0;
        div_zero <= 1'b0;
      end else if (state == RUN) begin
        h   <= h_nx;
        l   <= l_nx;
        cnt <= cnt + 1'b1;
        if (finish) begin
          done     <= 1'b1;
          res_hi   <= res_nx[2*WIDTH-1:WIDTH];
          res_lo   <= res_nx[WIDTH-1:0];
          div_zero <= is_div && (m == '0);
        end
      end
    end
  end

endmodule
